// File: rtl/sd_drive_arbiter.sv
// sd_drive_arbiter
// Round-robin sequencer that shares the hps_io SD sector interface (VDNUM=2)
// between the two virtual floppy drives. One drive at a time owns sd_lba, the
// rd/wr strobes and the buffer write strobe; completion is reported per drive.
// Optional watchdog: define SD_ARB_TIMEOUT_EN to abort a transfer whose ack
// handshake does not finish within TIMEOUT_CYCLES clk_sys cycles.
`timescale 1ns/1ps
module sd_drive_arbiter #(
  parameter bit WR_FIRST       = 1'b0,
  parameter int TIMEOUT_CYCLES = 4_000_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req_lba0,
  input  logic [31:0] req_lba1,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  output logic [31:0] sd_lba,
  input  logic [1:0]  sd_ack,
  input  logic        sd_buff_wr,
  output logic [1:0]  buff_wr,
  output logic        grant,
  output logic        busy,
  output logic [1:0]  done,
  output logic [1:0]  timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic        last_grant;
  logic        op_wr;
  logic [1:0]  pend;
  logic        sel;
  logic        sel_op_wr;
  logic [31:0] sel_lba;
  logic [1:0]  grant_oh;
  logic        tmo_hit;

  // Pick the next owner: a lone requester wins, a tie goes to the drive that
  // was not served last; a drive holding both rd and wr runs WR_FIRST's op.
  always_comb begin
    pend      = req_rd | req_wr;
    sel       = (pend == 2'b11) ? ~last_grant : pend[1];
    sel_op_wr = (req_rd[sel] & req_wr[sel]) ? WR_FIRST : req_wr[sel];
    sel_lba   = sel ? req_lba1 : req_lba0;
  end

  assign grant_oh = {grant, ~grant};
  assign busy     = (state != IDLE);
  assign buff_wr  = ((state == XFER) && sd_buff_wr) ? grant_oh : 2'b00;

`ifdef SD_ARB_TIMEOUT_EN
  localparam logic [22:0] TMO_LAST = 23'(TIMEOUT_CYCLES - 1);

  logic [22:0] tmo_cnt;
  logic [1:0]  tmo_err_q;

  assign tmo_hit     = ((state == REQ) || (state == XFER)) && (tmo_cnt == TMO_LAST);
  assign timeout_err = tmo_err_q;

  // Watchdog counter restarts at each grant and runs while a transfer is open.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 2'b00;
    end else begin
      tmo_err_q <= tmo_hit ? grant_oh : 2'b00;
      if ((state == IDLE) && (pend != 2'b00)) begin
        tmo_cnt <= '0;
      end else if ((state == REQ) || (state == XFER)) begin
        tmo_cnt <= tmo_cnt + 23'd1;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 2'b00;
`endif

  // Transfer sequencer: grant, strobe until ack, wait for ack release, report done.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sd_rd      <= 2'b00;
      sd_wr      <= 2'b00;
      sd_lba     <= 32'd0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      op_wr      <= 1'b0;
      done       <= 2'b00;
    end else begin
      done <= 2'b00;
      case (state)
        IDLE: begin
          if (pend != 2'b00) begin
            grant  <= sel;
            op_wr  <= sel_op_wr;
            sd_lba <= sel_lba;
            state  <= REQ;
          end
        end
        REQ: begin
          if (sd_ack[grant]) begin
            sd_rd <= 2'b00;
            sd_wr <= 2'b00;
            state <= XFER;
          end else begin
            sd_rd <= op_wr ? 2'b00 : grant_oh;
            sd_wr <= op_wr ? grant_oh : 2'b00;
          end
        end
        XFER: begin
          if (!sd_ack[grant]) begin
            done  <= grant_oh;
            state <= DONE;
          end
        end
        DONE: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (tmo_hit) begin
        sd_rd      <= 2'b00;
        sd_wr      <= 2'b00;
        done       <= 2'b00;
        last_grant <= grant;
        state      <= IDLE;
      end
    end
  end

endmodule
